alarm_ring_sequencer: RTL and testbench
=======================================

// Module: alarm_ring_sequencer
// PURPOSE
//  Sequences the alarm sound once the comparators flag an alarm match: ring, snooze, re-ring, stop and timeout.
//  Sits between the comparator match output and the Sound pin.
//  Takes the Snooze/Stop/Mute buttons and a once-per-minute tick from the current-time counter.
//  Intended replacement for the second (sound) control unit; the datapath registers are untouched.
// PARAMETERS
//  SNOOZE_MIN  5   minutes silent per snooze before re-ringing (1..15)
//  RING_MAX    10  minutes a ring may last before auto-stop (1..15)
//  MAX_SNOOZE  3   snoozes allowed per alarm event; further Snooze presses are ignored (0..15)
// PORTS
//  Clk         in   1  system clock; all state changes on rising edge
//  Clr         in   1  asynchronous, active-low reset
//  MinTick     in   1  one-cycle pulse at every minute rollover of current time
//  AlarmMatch  in   1  level; high while current time equals an enabled alarm register
//  AlarmEn     in   1  level; global alarm enable (low aborts any ring/snooze)
//  Snooze      in   1  button level, synchronised upstream
//  Stop        in   1  button level, synchronised upstream
//  Mute        in   1  level; gates Sound only, sequencing continues
//  Sound       out  1  buzzer drive = Ringing & ~Mute (combinational from state reg)
//  Ringing     out  1  high in RING
//  Snoozing    out  1  high in SNOOZE
//  SnoozeCnt   out  4  snoozes taken in current alarm event
//  MinLeft     out  4  minutes left in current RING/SNOOZE phase; 0 otherwise
// BEHAVIOUR
//  Reset (Clr=0, async): state=IDLE; Sound, Ringing, Snoozing = 0; SnoozeCnt, MinLeft = 0.
//  Reset also clears the minute counter and the button edge registers.
//  Button edges: snz_e = Snooze & ~snz_q, stp_e = Stop & ~stp_q; snz_q/stp_q are registered each cycle.
//  A held button acts once; a press already held at reset release does not fire.
//  Each transition takes effect at the clock edge that samples its qualifying input (1-cycle latency to outputs).
//  min_cnt (4 bit) counts MinTick pulses within a phase; cleared on every phase entry.
//  States:
//   IDLE: AlarmEn & AlarmMatch -> RING; min_cnt=0; SnoozeCnt=0.
//   RING, checked in priority order:
//    1. stp_e | ~AlarmEn -> DONE.
//    2. snz_e & SnoozeCnt<MAX_SNOOZE -> SNOOZE; SnoozeCnt+1; min_cnt=0.
//       snz_e with SnoozeCnt==MAX_SNOOZE: ignored.
//    3. MinTick & min_cnt==RING_MAX-1 -> DONE (timeout).
//    4. else MinTick -> min_cnt+1.
//   SNOOZE, checked in priority order:
//    1. stp_e | ~AlarmEn -> DONE.
//    2. MinTick & min_cnt==SNOOZE_MIN-1 -> RING; min_cnt=0.
//    3. else MinTick -> min_cnt+1.
//    snz_e is ignored.
//   DONE: all outputs 0; SnoozeCnt cleared. AlarmMatch==0 -> IDLE.
//    Holding in DONE prevents re-triggering within the matching minute.
//  MinLeft = RING_MAX-min_cnt in RING, SNOOZE_MIN-min_cnt in SNOOZE, else 0.
//  Simultaneous events:
//   - Stop beats Snooze.
//   - Snooze beats timeout in the same cycle.
//   - AlarmEn low beats everything except reset.
//  Mute toggling never changes state, counters or Ringing; only Sound.
//  MinTick while in IDLE or DONE has no effect.
//  Reset asserted mid-RING/SNOOZE: Sound drops immediately (async); returns to IDLE.
//   If AlarmMatch is still high after reset release, ring restarts the next cycle with SnoozeCnt=0.
// TESTING
//  1. AlarmEn=1, pulse AlarmMatch; no buttons; 10 MinTicks -> Ringing=1 next cycle, MinLeft 10..1,
//     Ringing=0 on the 10th tick edge, state DONE until AlarmMatch=0.
//  2. Ring, press Snooze -> Snoozing=1, SnoozeCnt=1, Sound=0; 5 MinTicks -> Ringing=1 again, MinLeft=10.
//  3. Snooze 3 times through re-rings, 4th Snooze press -> ignored, Ringing stays 1, SnoozeCnt=3.
//  4. Snooze and Stop asserted the same cycle in RING -> DONE, SnoozeCnt=0, Sound=0.
//     Snooze held 20 cycles -> counts once.
//  5. Ring with Mute=1 -> Sound=0 while Ringing=1; Mute=0 -> Sound=1 same cycle; MinLeft unaffected.
//  6. Clr=0 mid-SNOOZE with AlarmMatch still high -> outputs 0 immediately;
//     after release Ringing=1 next cycle, SnoozeCnt=0. AlarmEn dropped in RING -> DONE next edge.

Source files
------------

// File: rtl/alarm_ring_sequencer.sv
// alarm_ring_sequencer
//   Sound control unit for the alarm clock. Once the comparators flag an
//   alarm match, it rings, snoozes and re-rings. It stops on the Stop button,
//   on alarm disable, or on ring timeout.
// Ports
//   Clk, Clr          clock (rising edge) / async active-low reset
//   MinTick           one-cycle pulse per minute rollover of current time
//   AlarmMatch        level, current time equals an enabled alarm
//   AlarmEn           level, global enable; low aborts ring/snooze
//   Snooze, Stop      synchronised button levels (edge-detected here)
//   Mute              gates Sound only
//   Sound             Ringing & ~Mute
//   Ringing/Snoozing  state flags
//   SnoozeCnt         snoozes taken in the current alarm event
//   MinLeft           minutes left in the current RING/SNOOZE phase, else 0
module alarm_ring_sequencer #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MAX   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       MinTick,
  input  logic       AlarmMatch,
  input  logic       AlarmEn,
  input  logic       Snooze,
  input  logic       Stop,
  input  logic       Mute,
  output logic       Sound,
  output logic       Ringing,
  output logic       Snoozing,
  output logic [3:0] SnoozeCnt,
  output logic [3:0] MinLeft
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

  localparam logic [3:0] RING_LEN  = 4'(RING_MAX);
  localparam logic [3:0] SNZ_LEN   = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LAST = 4'(RING_MAX - 1);
  localparam logic [3:0] SNZ_LAST  = 4'(SNOOZE_MIN - 1);
  localparam logic [3:0] SNZ_LIM   = 4'(MAX_SNOOZE);

  state_t     state, state_n;
  logic [3:0] min_cnt, min_cnt_n;
  logic [3:0] snz_cnt, snz_cnt_n;
  logic       snz_q, stp_q;
  logic       snz_e, stp_e;

  assign snz_e = Snooze & ~snz_q;
  assign stp_e = Stop & ~stp_q;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      min_cnt <= '0;
      snz_cnt <= '0;
      snz_q   <= 1'b0;
      stp_q   <= 1'b0;
    end else begin
      state   <= state_n;
      min_cnt <= min_cnt_n;
      snz_cnt <= snz_cnt_n;
      snz_q   <= Snooze;
      stp_q   <= Stop;
    end
  end

  always_comb begin
    state_n   = state;
    min_cnt_n = min_cnt;
    snz_cnt_n = snz_cnt;
    case (state)
      IDLE: begin
        if (AlarmEn && AlarmMatch) begin
          state_n   = RING;
          min_cnt_n = '0;
          snz_cnt_n = '0;
        end
      end
      RING: begin
        // Stop/disable outrank snooze, and snooze outranks timeout.
        // A snooze past the limit falls through to the timeout check.
        if (stp_e || !AlarmEn) begin
          state_n   = DONE;
          snz_cnt_n = '0;
        end else if (snz_e && (snz_cnt < SNZ_LIM)) begin
          state_n   = SNOOZE;
          snz_cnt_n = snz_cnt + 4'd1;
          min_cnt_n = '0;
        end else if (MinTick && (min_cnt == RING_LAST)) begin
          state_n   = DONE;
          snz_cnt_n = '0;
        end else if (MinTick) begin
          min_cnt_n = min_cnt + 4'd1;
        end
      end
      SNOOZE: begin
        if (stp_e || !AlarmEn) begin
          state_n   = DONE;
          snz_cnt_n = '0;
        end else if (MinTick && (min_cnt == SNZ_LAST)) begin
          state_n   = RING;
          min_cnt_n = '0;
        end else if (MinTick) begin
          min_cnt_n = min_cnt + 4'd1;
        end
      end
      DONE: begin
        // Stay here until the matching minute passes, so the same match
        // cannot re-trigger the alarm.
        snz_cnt_n = '0;
        min_cnt_n = '0;
        if (!AlarmMatch) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign Ringing   = (state == RING);
  assign Snoozing  = (state == SNOOZE);
  assign Sound     = Ringing & ~Mute;
  assign SnoozeCnt = snz_cnt;

  always_comb begin
    MinLeft = '0;
    if (state == RING)   MinLeft = RING_LEN - min_cnt;
    if (state == SNOOZE) MinLeft = SNZ_LEN - min_cnt;
  end

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// tb_alarm_ring_sequencer
//   Scoreboard bench. Each step() clocks the DUT once and advances a
//   behavioural model of the sequencer. It pushes the model's expected
//   outputs, then pops and compares them against the DUT after the edge.
//   Directed constant checks pin down the key scenario values.
module tb_alarm_ring_sequencer;

  localparam int SNOOZE_MIN = 5;
  localparam int RING_MAX   = 10;
  localparam int MAX_SNOOZE = 3;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       MinTick = 1'b0, AlarmMatch = 1'b0, AlarmEn = 1'b0;
  logic       Snooze = 1'b0, Stop = 1'b0, Mute = 1'b0;
  logic       Sound, Ringing, Snoozing;
  logic [3:0] SnoozeCnt, MinLeft;

  alarm_ring_sequencer #(
    .SNOOZE_MIN(SNOOZE_MIN), .RING_MAX(RING_MAX), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .Clk(Clk), .Clr(Clr), .MinTick(MinTick), .AlarmMatch(AlarmMatch),
    .AlarmEn(AlarmEn), .Snooze(Snooze), .Stop(Stop), .Mute(Mute),
    .Sound(Sound), .Ringing(Ringing), .Snoozing(Snoozing),
    .SnoozeCnt(SnoozeCnt), .MinLeft(MinLeft)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       ring;
    logic       snz;
    logic       sound;
    logic [3:0] cnt;
    logic [3:0] ml;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model state: 0 idle, 1 ring, 2 snooze, 3 done
  int m_st = 0, m_min = 0, m_cnt = 0;
  bit m_snzq = 0, m_stpq = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_min = 0; m_cnt = 0; m_snzq = 0; m_stpq = 0;
  endtask

  task automatic model_clock();
    bit se, pe;
    se = Snooze & ~m_snzq;
    pe = Stop & ~m_stpq;
    m_snzq = Snooze;
    m_stpq = Stop;
    case (m_st)
      0: if (AlarmEn && AlarmMatch) begin m_st = 1; m_min = 0; m_cnt = 0; end
      1: begin
        if (pe || !AlarmEn) begin m_st = 3; m_cnt = 0; end
        else if (se && m_cnt < MAX_SNOOZE) begin m_st = 2; m_cnt++; m_min = 0; end
        else if (MinTick && m_min == RING_MAX - 1) begin m_st = 3; m_cnt = 0; end
        else if (MinTick) m_min++;
      end
      2: begin
        if (pe || !AlarmEn) begin m_st = 3; m_cnt = 0; end
        else if (MinTick && m_min == SNOOZE_MIN - 1) begin m_st = 1; m_min = 0; end
        else if (MinTick) m_min++;
      end
      default: begin m_min = 0; if (!AlarmMatch) m_st = 0; end
    endcase
  endtask

  task automatic step();
    exp_t e, o;
    @(posedge Clk);
    model_clock();
    e.ring  = (m_st == 1);
    e.snz   = (m_st == 2);
    e.sound = (m_st == 1) && !Mute;
    e.cnt   = 4'(m_cnt);
    e.ml    = (m_st == 1) ? 4'(RING_MAX - m_min) : (m_st == 2) ? 4'(SNOOZE_MIN - m_min) : 4'd0;
    q.push_back(e);
    #1;
    o = q.pop_front();
    chk("ringing", 32'(Ringing), 32'(o.ring));
    chk("snoozing", 32'(Snoozing), 32'(o.snz));
    chk("sound", 32'(Sound), 32'(o.sound));
    chk("snzcnt", 32'(SnoozeCnt), 32'(o.cnt));
    chk("minleft", 32'(MinLeft), 32'(o.ml));
    MinTick = 1'b0;
  endtask

  task automatic tick();
    MinTick = 1'b1;
    step();
  endtask

  // pulse AlarmMatch for one cycle from IDLE
  task automatic start_ring();
    AlarmMatch = 1'b1;
    step();
    AlarmMatch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_ringing", 32'(Ringing), 0);
    chk("rst_sound", 32'(Sound), 0);
    chk("rst_minleft", 32'(MinLeft), 0);
    chk("rst_cnt", 32'(SnoozeCnt), 0);
    // Snooze held across reset release must not act later
    Snooze = 1'b1;
    #10 Clr = 1'b1; AlarmEn = 1'b1;
    model_reset();
    step();
    // MinTick in IDLE has no effect
    tick();
    Snooze = 1'b0;
    step();

    // 1: full timeout
    start_ring();
    chk("t1_ring", 32'(Ringing), 1);
    chk("t1_ml10", 32'(MinLeft), 10);
    for (int i = 0; i < RING_MAX; i++) begin tick(); step(); end
    chk("t1_timeout", 32'(Ringing), 0);
    step();

    // 2/3: snooze, re-ring, limit reached
    start_ring();
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      Snooze = 1'b1; step();
      chk("t2_snoozing", 32'(Snoozing), 1);
      chk("t2_cnt", 32'(SnoozeCnt), 32'(k));
      chk("t2_sound", 32'(Sound), 0);
      Snooze = 1'b0; step();
      for (int i = 0; i < SNOOZE_MIN; i++) tick();
      chk("t2_rering", 32'(Ringing), 1);
      chk("t2_ml", 32'(MinLeft), 10);
    end
    Snooze = 1'b1; step();
    chk("t3_ignored", 32'(Ringing), 1);
    chk("t3_cnt", 32'(SnoozeCnt), 3);
    Snooze = 1'b0; Stop = 1'b1; step();
    Stop = 1'b0; step(); step();

    // 4: Stop beats Snooze; held Snooze counts once
    start_ring();
    Snooze = 1'b1; Stop = 1'b1; step();
    chk("t4_done", 32'(Ringing | Snoozing), 0);
    chk("t4_cnt", 32'(SnoozeCnt), 0);
    Snooze = 1'b0; Stop = 1'b0; step();
    start_ring();
    Snooze = 1'b1;
    repeat (20) step();
    chk("t4_held", 32'(SnoozeCnt), 1);
    Snooze = 1'b0; Stop = 1'b1; step();
    Stop = 1'b0; step();

    // Snooze beats timeout in the same cycle
    start_ring();
    repeat (RING_MAX - 1) tick();
    Snooze = 1'b1; tick();
    chk("snz_vs_to", 32'(Snoozing), 1);
    Snooze = 1'b0; step();
    AlarmEn = 1'b0; step();
    chk("en_abort_snz", 32'(Snoozing), 0);
    AlarmEn = 1'b1; step();

    // 5: Mute gates Sound only
    Mute = 1'b1;
    start_ring();
    tick(); tick();
    chk("t5_muted", 32'(Sound), 0);
    chk("t5_ml", 32'(MinLeft), 8);
    Mute = 1'b0; #1;
    chk("t5_unmute", 32'(Sound), 1);
    step();

    // 6: async reset mid-SNOOZE, match still high
    Stop = 1'b1; step(); Stop = 1'b0; step();
    start_ring();
    Snooze = 1'b1; step(); Snooze = 1'b0; tick();
    AlarmMatch = 1'b1;
    Clr = 1'b0; #1;
    model_reset();
    chk("t6_rst_snz", 32'(Snoozing), 0);
    chk("t6_rst_cnt", 32'(SnoozeCnt), 0);
    #1 Clr = 1'b1;
    step();
    chk("t6_rering", 32'(Ringing), 1);
    chk("t6_cnt0", 32'(SnoozeCnt), 0);
    AlarmEn = 1'b0; step();
    chk("t6_en_abort", 32'(Ringing), 0);
    AlarmMatch = 1'b0; step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
